grid_renderer: RTL

Parametrised LCD renderer. It converts single grid-cell update requests (cell coordinate plus object code) into MIPI-DBI Type-B (8080-style) command/data sequences for an ILI9341-class panel. It sits between the game-side frame tracker and the panel pins, and adds three things over the earlier fixed-size pixel path:

- a built-in panel init sequence;
- a valid/ready cell handshake;
- configurable grid, cell size and bus width.

---
 rtl/grid_renderer_pkg.sv | 45 ++++
 rtl/grid_renderer_bus_writer.sv | 66 ++++++
 rtl/grid_renderer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/grid_renderer_pkg.sv
// grid_renderer shared types and constants
// Sequencer states, panel commands, object codes and palette
package grid_renderer_pkg;

  typedef enum logic [1:0] {
    ST_UNINIT,
    ST_INIT,
    ST_IDLE,
    ST_CELL
  } state_t;

  typedef enum logic [2:0] {
    OBJ_EMPTY,
    OBJ_BODY,
    OBJ_HEAD,
    OBJ_APPLE,
    OBJ_BORDER,
    OBJ_RSV5,
    OBJ_RSV6,
    OBJ_RSV7
  } obj_t;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  // RGB565 colour for an object code; reserved codes draw black
  function automatic logic [15:0] palette(input logic [2:0] code);
    logic [15:0] c;
    case (obj_t'(code))
      OBJ_BODY:   c = 16'h07E0;
      OBJ_HEAD:   c = 16'h03E0;
      OBJ_APPLE:  c = 16'hF800;
      OBJ_BORDER: c = 16'hFFFF;
      default:    c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/grid_renderer_bus_writer.sv
// lcd_bus_writer: word handshake to 8080-style strobes
// Two cycles per word, csx held low across a frame of words
module lcd_bus_writer #(
  parameter int BUS_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [BUS_W-1:0] i_word,
  input  logic             i_dcx,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_fin,
  output logic             o_csx,
  output logic             o_dcx,
  output logic             o_wrx,
  output logic [BUS_W-1:0] o_d
);

  logic             r_act;
  logic             r_ph;
  logic             r_last;
  logic             r_csx;
  logic             r_dcx;
  logic             r_wrx;
  logic [BUS_W-1:0] r_d;
  logic             w_take;

  // A new word may be taken when idle or in phase B of the current one
  assign o_ready = !r_act || r_ph;
  assign o_fin   = r_act && r_ph && r_last;
  assign w_take  = i_valid && o_ready;
  assign o_csx   = r_csx;
  assign o_dcx   = r_dcx;
  assign o_wrx   = r_wrx;
  assign o_d     = r_d;

  // Phase A drives wrx low, phase B releases it; csx rises after the last word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act  <= 1'b0;
      r_ph   <= 1'b0;
      r_last <= 1'b0;
      r_csx  <= 1'b1;
      r_dcx  <= 1'b1;
      r_wrx  <= 1'b1;
      r_d    <= '0;
    end else if (w_take) begin
      r_act  <= 1'b1;
      r_ph   <= 1'b0;
      r_last <= i_last;
      r_csx  <= 1'b0;
      r_wrx  <= 1'b0;
      r_dcx  <= i_dcx;
      r_d    <= i_word;
    end else if (r_act && !r_ph) begin
      r_ph  <= 1'b1;
      r_wrx <= 1'b1;
    end else if (o_fin) begin
      r_act <= 1'b0;
      r_ph  <= 1'b0;
      r_csx <= 1'b1;
    end
  end

endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: cell requests to ILI9341 command/data sequences
// Sequencer FSM, address arithmetic, pixel and wait counters
module grid_renderer
  import grid_renderer_pkg::*;
#(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int CELL_PX   = 15,
  parameter int X_OFS     = 0,
  parameter int Y_OFS     = 0,
  parameter int BUS_W     = 8,
  parameter int INIT_WAIT = 600000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_init,
  output logic                      init_done,
  input  logic                      cell_valid,
  output logic                      cell_ready,
  input  logic [$clog2(GRID_W)-1:0] cell_x,
  input  logic [$clog2(GRID_H)-1:0] cell_y,
  input  logic [2:0]                obj_code,
  output logic                      busy,
  output logic                      err_range,
  output logic                      lcd_csx,
  output logic                      lcd_dcx,
  output logic                      lcd_wrx,
  output logic [BUS_W-1:0]          lcd_d
);

  localparam int NPW = CELL_PX * CELL_PX * ((BUS_W == 16) ? 1 : 2);
  localparam int PW  = $clog2(CELL_PX * CELL_PX * 2 + 1);
  localparam int WW  = $clog2(INIT_WAIT + 1);

  state_t          r_state, w_nx_state;
  logic [3:0]      r_step, w_nx_step;
  logic [WW-1:0]   r_wait, w_nx_wait;
  logic [PW-1:0]   r_pix, w_nx_pix;
  logic            r_done, w_nx_done;
  logic            r_err, w_nx_err;
  logic [15:0]     r_x0, r_y0, r_col;
  logic [15:0]     w_x1, w_y1;
  logic            w_accept, w_oor;
  logic            w_v, w_dcx, w_last, w_is_pix;
  logic [7:0]      w_byte;
  logic [BUS_W-1:0] w_word, w_pixw;
  logic            w_rdy, w_fin;

  assign cell_ready = (r_state == ST_IDLE) && r_done && !r_err
                      && !start_init;
  assign w_accept   = cell_valid && cell_ready;
  assign w_oor      = (int'(cell_x) >= GRID_W) || (int'(cell_y) >= GRID_H);
  assign busy       = (r_state == ST_INIT) || (r_state == ST_CELL);
  assign init_done  = r_done;
  assign err_range  = r_err;
  assign w_x1       = r_x0 + 16'(CELL_PX - 1);
  assign w_y1       = r_y0 + 16'(CELL_PX - 1);
  assign w_pixw     = (BUS_W == 16) ? BUS_W'(r_col)
                    : BUS_W'(r_pix[0] ? r_col[7:0] : r_col[15:8]);
  assign w_word     = w_is_pix ? w_pixw : BUS_W'(w_byte);

  // Sequencer state and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_UNINIT;
      r_step  <= '0;
      r_wait  <= '0;
      r_pix   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_step  <= w_nx_step;
      r_wait  <= w_nx_wait;
      r_pix   <= w_nx_pix;
      r_done  <= w_nx_done;
      r_err   <= w_nx_err;
    end
  end

  // Capture cell origin and colour on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0  <= '0;
      r_y0  <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      r_x0  <= 16'(X_OFS) + 16'(cell_x) * 16'(CELL_PX);
      r_y0  <= 16'(Y_OFS) + 16'(cell_y) * 16'(CELL_PX);
      r_col <= palette(obj_code);
    end
  end

  // Next-state logic and word selection for the bus writer
  always_comb begin
    w_nx_state = r_state;
    w_nx_step  = r_step;
    w_nx_wait  = r_wait;
    w_nx_pix   = r_pix;
    w_nx_done  = r_done;
    w_nx_err   = 1'b0;
    w_v        = 1'b0;
    w_byte     = 8'h00;
    w_dcx      = 1'b0;
    w_last     = 1'b0;
    w_is_pix   = 1'b0;
    unique case (r_state)
      ST_UNINIT: begin
        if (start_init) begin
          w_nx_state = ST_INIT;
          w_nx_step  = 4'd0;
        end
      end
      ST_IDLE: begin
        if (start_init) begin
          w_nx_state = ST_INIT;
          w_nx_step  = 4'd0;
          w_nx_done  = 1'b0;
        end else if (w_accept) begin
          if (w_oor) begin
            w_nx_err = 1'b1;
          end else begin
            w_v        = 1'b1;
            w_byte     = CMD_CASET;
            w_nx_state = ST_CELL;
            w_nx_step  = 4'd1;
            w_nx_pix   = '0;
          end
        end
      end
      ST_INIT: begin
        case (r_step)
          4'd0, 4'd2: begin
            if (r_step == 4'd0 || r_wait == '0) begin
              w_v    = 1'b1;
              w_last = 1'b1;
              w_byte = (r_step == 4'd0) ? CMD_SWRESET : CMD_SLPOUT;
              if (w_rdy) w_nx_step = r_step + 4'd1;
            end else begin
              w_nx_wait = r_wait - WW'(1);
            end
          end
          4'd1, 4'd3: begin
            if (w_fin) begin
              w_nx_wait = WW'(INIT_WAIT - 1);
              w_nx_step = r_step + 4'd1;
            end
          end
          4'd4: begin
            if (r_wait == '0) begin
              w_v    = 1'b1;
              w_byte = CMD_COLMOD;
              if (w_rdy) w_nx_step = 4'd5;
            end else begin
              w_nx_wait = r_wait - WW'(1);
            end
          end
          4'd5, 4'd6, 4'd7, 4'd8: begin
            w_v    = 1'b1;
            w_dcx  = (r_step == 4'd5) || (r_step == 4'd7);
            w_last = (r_step == 4'd8);
            w_byte = (r_step == 4'd5) ? 8'h55
                   : (r_step == 4'd6) ? CMD_MADCTL
                   : (r_step == 4'd7) ? 8'h00 : CMD_DISPON;
            if (w_rdy) w_nx_step = r_step + 4'd1;
          end
          default: begin
            if (w_fin) begin
              w_nx_done  = 1'b1;
              w_nx_state = ST_IDLE;
            end
          end
        endcase
      end
      ST_CELL: begin
        case (r_step)
          4'd11: begin
            w_v      = 1'b1;
            w_dcx    = 1'b1;
            w_is_pix = 1'b1;
            w_last   = (r_pix == PW'(NPW - 1));
            if (w_rdy) begin
              w_nx_pix = r_pix + PW'(1);
              if (w_last) w_nx_step = 4'd12;
            end
          end
          4'd12: begin
            if (w_fin) w_nx_state = ST_IDLE;
          end
          default: begin
            w_v   = 1'b1;
            w_dcx = (r_step != 4'd5) && (r_step != 4'd10);
            unique case (1'b1)
              r_step == 4'd1: w_byte = r_x0[15:8];
              r_step == 4'd2: w_byte = r_x0[7:0];
              r_step == 4'd3: w_byte = w_x1[15:8];
              r_step == 4'd4: w_byte = w_x1[7:0];
              r_step == 4'd5: w_byte = CMD_RASET;
              r_step == 4'd6: w_byte = r_y0[15:8];
              r_step == 4'd7: w_byte = r_y0[7:0];
              r_step == 4'd8: w_byte = w_y1[15:8];
              r_step == 4'd9: w_byte = w_y1[7:0];
              default:        w_byte = CMD_RAMWR;
            endcase
            if (w_rdy) w_nx_step = r_step + 4'd1;
          end
        endcase
      end
    endcase
  end

  lcd_bus_writer #(.BUS_W(BUS_W)) u_wr (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (w_v),
    .i_word  (w_word),
    .i_dcx   (w_dcx),
    .i_last  (w_last),
    .o_ready (w_rdy),
    .o_fin   (w_fin),
    .o_csx   (lcd_csx),
    .o_dcx   (lcd_dcx),
    .o_wrx   (lcd_wrx),
    .o_d     (lcd_d)
  );

endmodule
